rv_program_loader: RTL and testbench
====================================

// Module: rv_program_loader
// PURPOSE
// - Inverse of the main control decoder: accepts symbolic RV32I instruction requests (kind, regs, funct, imm),
//   encodes them into 32-bit instruction words and writes them sequentially into instruction memory.
// - Sits between the test/boot sequencer and the instruction-memory write port of the single-cycle core.
// - Includes a valid/ready request handshake, a 1-stage encode pipeline, an address counter and a load FSM.
// PARAMETERS
// - ADDR_W     8    instruction-memory word-address width
// - BASE_ADDR  0    first word address written after START
// PORTS
// - CLK         in   1       clock, rising edge
// - RST_N       in   1       asynchronous active-low reset
// - START       in   1       1-cycle pulse: begin a program load at BASE_ADDR
// - REQ_VALID   in   1       request valid
// - REQ_READY   out  1       loader can accept a request this cycle
// - REQ_KIND    in   4       instr_kind_t: R, I_ALU, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR
// - REQ_FUNCT3  in   3       funct3 field (ignored for LUI/AUIPC/JAL)
// - REQ_F7B5    in   1       instr bit 30 (R: SUB/SRA; I_ALU with funct3 101: SRAI)
// - REQ_RD      in   5       destination register
// - REQ_RS1     in   5       source register 1
// - REQ_RS2     in   5       source register 2
// - REQ_IMM     in   32      signed byte-offset / immediate (U kinds: full 32-bit value)
// - REQ_LAST    in   1       this request is the final instruction of the program
// - MEM_WE      out  1       instruction-memory write enable
// - MEM_ADDR    out  ADDR_W  word address of the write
// - MEM_WDATA   out  32      encoded instruction word
// - BUSY        out  1       load in progress (FSM not IDLE)
// - DONE        out  1       1-cycle pulse after the LAST word is written
// - ERR         out  1       sticky error; cleared only by START or reset
// - COUNT       out  ADDR_W  number of words written in the current load
// BEHAVIOUR
// - Reset: all outputs 0, MEM_ADDR=BASE_ADDR, FSM=IDLE. Reset asserted mid-load aborts immediately; no further writes.
// - FSM: IDLE --START--> LOAD --accepted LAST write--> FIN --> IDLE. Any error in LOAD -> IDLE with ERR=1.
// - IDLE: REQ_READY=0. START clears ERR and COUNT, loads the address counter with BASE_ADDR. START outside IDLE is ignored.
// - LOAD: REQ_READY=1 unless the LAST request has been accepted. Handshake = REQ_VALID & REQ_READY.
// - Latency: a request accepted in cycle N produces MEM_WE=1 with MEM_WDATA/MEM_ADDR in cycle N+1. Throughput is 1/cycle.
// - After each write: address +1, COUNT +1.
// - Opcodes: R 0110011, I_ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, LUI 0110111, AUIPC 0010111,
//   JAL 1101111, JALR 1100111 (JALR funct3 forced 000).
// - Immediate packing follows the RV32I I/S/B/U/J formats.
//   - I_ALU with funct3 001/101: imm[4:0] goes to shamt, bit30=REQ_F7B5, other bits 0.
// - Range checks (fail => error):
//   - I/S: -2048..2047. B: -4096..4094, even. J: +/-1 MiB, even. U: imm[11:0]==0.
//   - Shift: 0..31. Kind outside the enum is also an error.
// - Error behaviour: the offending request is accepted but not written. ERR=1. FSM -> IDLE, and the next cycle has no write.
// - Wrap-around: if a write lands on address 2^ADDR_W-1 and it is not LAST:
//   - ERR=1, FSM -> IDLE after that write. The counter never wraps into BASE_ADDR silently.
// - FIN: DONE=1 for exactly one cycle. BUSY drops in the same cycle. The next START is accepted from the following cycle.
// - Simultaneous events:
//   - A LAST handshake that is also a range error reports ERR, not DONE.
//   - Reset dominates all other events.
// STRUCTURE
// - Package rv_enc_pkg: instr_kind_t enum, OPC_* 7-bit opcode constants, IMM range limits.
//   The control decoder reuses the same OPC_* constants.
// - Sub-module rv_instr_encoder: purely combinational; kind/fields/imm in, {word[31:0], illegal} out.
// - Top level holds the FSM, the pipeline register, the address counter and COUNT.
// TESTING
// - ADDI x1,x0,5 then LAST ADD x3,x1,x2 from BASE_ADDR=0:
//   - writes 0x00500093@0 and 0x002081B3@1.
//   - DONE pulses 1 cycle after the last write. COUNT=2.
// - SW x2,8(x1) -> 0x0020A423. BEQ x1,x2,+8 -> 0x00208463. JAL x1,+16 -> 0x010000EF. LUI x5,0x12345000 -> 0x123452B7.
// - Back-to-back REQ_VALID for 4 cycles: 4 consecutive MEM_WE cycles, addresses 0..3. A REQ_VALID gap inserts a MEM_WE=0 bubble.
// - Range errors: ADDI imm=2048 -> no write, ERR=1, BUSY=0.
//   Also check BRANCH imm=3 and LUI imm=0x00000001 the same way. Then START clears ERR.
// - ADDR_W=2: a 5-instruction program writes addresses 0..3, then ERR=1 and no write to address 0.
// - RST_N low mid-burst: outputs 0 asynchronously. After release, START runs a clean load from BASE_ADDR.

Source files
------------

// File: rtl/rv_enc_pkg.sv
// Shared RV32I encoding definitions: request kinds, major opcodes, immediate limits.
// The control decoder decodes against the same OPC_* constants.
package rv_enc_pkg;

    typedef enum logic [3:0] {
        KIND_R      = 4'd0,
        KIND_I_ALU  = 4'd1,
        KIND_LOAD   = 4'd2,
        KIND_STORE  = 4'd3,
        KIND_BRANCH = 4'd4,
        KIND_LUI    = 4'd5,
        KIND_AUIPC  = 4'd6,
        KIND_JAL    = 4'd7,
        KIND_JALR   = 4'd8
    } instr_kind_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FIN  = 2'd2
    } load_state_t;

    typedef struct packed {
        instr_kind_t kind;
        logic [2:0]  funct3;
        logic        f7b5;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } enc_req_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam int IMM_I_MIN = -2048;
    localparam int IMM_I_MAX = 2047;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4094;
    localparam int IMM_J_MIN = -1048576;
    localparam int IMM_J_MAX = 1048574;
    localparam int SHAMT_MAX = 31;

    function automatic logic in_range(input logic signed [31:0] v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/rv_instr_encoder.sv
// Combinational RV32I encoder: symbolic request in, 32-bit word plus illegal flag out.
module rv_instr_encoder
    import rv_enc_pkg::*;
(
    input  enc_req_t    req_i,
    output logic [31:0] word_o,
    output logic        illegal_o
);

    logic signed [31:0] imm;
    logic               is_shift;

    assign imm      = req_i.imm;
    assign is_shift = (req_i.funct3 == 3'b001) || (req_i.funct3 == 3'b101);

    always_comb begin
        word_o    = '0;
        illegal_o = 1'b0;
        case (req_i.kind)
            KIND_R: begin
                word_o = {1'b0, req_i.f7b5, 5'b0, req_i.rs2, req_i.rs1, req_i.funct3, req_i.rd, OPC_R};
            end
            KIND_I_ALU: begin
                // Shifts carry shamt in imm[4:0]; bit 30 selects SRAI.
                if (is_shift) begin
                    word_o    = {1'b0, req_i.f7b5, 5'b0, imm[4:0], req_i.rs1, req_i.funct3, req_i.rd, OPC_I_ALU};
                    illegal_o = !in_range(imm, 0, SHAMT_MAX);
                end else begin
                    word_o    = {imm[11:0], req_i.rs1, req_i.funct3, req_i.rd, OPC_I_ALU};
                    illegal_o = !in_range(imm, IMM_I_MIN, IMM_I_MAX);
                end
            end
            KIND_LOAD: begin
                word_o    = {imm[11:0], req_i.rs1, req_i.funct3, req_i.rd, OPC_LOAD};
                illegal_o = !in_range(imm, IMM_I_MIN, IMM_I_MAX);
            end
            KIND_JALR: begin
                word_o    = {imm[11:0], req_i.rs1, 3'b000, req_i.rd, OPC_JALR};
                illegal_o = !in_range(imm, IMM_I_MIN, IMM_I_MAX);
            end
            KIND_STORE: begin
                word_o    = {imm[11:5], req_i.rs2, req_i.rs1, req_i.funct3, imm[4:0], OPC_STORE};
                illegal_o = !in_range(imm, IMM_I_MIN, IMM_I_MAX);
            end
            KIND_BRANCH: begin
                word_o    = {imm[12], imm[10:5], req_i.rs2, req_i.rs1, req_i.funct3,
                             imm[4:1], imm[11], OPC_BRANCH};
                illegal_o = !in_range(imm, IMM_B_MIN, IMM_B_MAX) || imm[0];
            end
            KIND_LUI: begin
                word_o    = {imm[31:12], req_i.rd, OPC_LUI};
                illegal_o = (imm[11:0] != 12'd0);
            end
            KIND_AUIPC: begin
                word_o    = {imm[31:12], req_i.rd, OPC_AUIPC};
                illegal_o = (imm[11:0] != 12'd0);
            end
            KIND_JAL: begin
                word_o    = {imm[20], imm[10:1], imm[11], imm[19:12], req_i.rd, OPC_JAL};
                illegal_o = !in_range(imm, IMM_J_MIN, IMM_J_MAX) || imm[0];
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/rv_program_loader.sv
// Program loader: accepts symbolic instruction requests, encodes them and writes them
// sequentially into instruction memory under control of a START/LOAD/FIN state machine.
module rv_program_loader
    import rv_enc_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [3:0]        REQ_KIND,
    input  logic [2:0]        REQ_FUNCT3,
    input  logic              REQ_F7B5,
    input  logic [4:0]        REQ_RD,
    input  logic [4:0]        REQ_RS1,
    input  logic [4:0]        REQ_RS2,
    input  logic [31:0]       REQ_IMM,
    input  logic              REQ_LAST,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [31:0]       MEM_WDATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR,
    output logic [ADDR_W-1:0] COUNT
);

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    load_state_t       state_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [31:0]       wdata_q;
    logic              we_q, wlast_q, hold_q;
    logic              err_q, busy_q, done_q;

    enc_req_t          enc_req;
    logic [31:0]       enc_word;
    logic              enc_illegal;
    logic              hs;

    assign enc_req = '{kind:   instr_kind_t'(REQ_KIND),
                       funct3: REQ_FUNCT3,
                       f7b5:   REQ_F7B5,
                       rd:     REQ_RD,
                       rs1:    REQ_RS1,
                       rs2:    REQ_RS2,
                       imm:    REQ_IMM};

    rv_instr_encoder u_enc (
        .req_i     (enc_req),
        .word_o    (enc_word),
        .illegal_o (enc_illegal)
    );

    // hold_q closes the request port while the final (LAST or top-address) write drains.
    assign REQ_READY = (state_q == ST_LOAD) && !hold_q;
    assign hs        = REQ_VALID && REQ_READY;
    assign addr_d    = addr_q + 1'b1;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            addr_q  <= BASE;
            count_q <= '0;
            waddr_q <= BASE;
            wdata_q <= '0;
            we_q    <= 1'b0;
            wlast_q <= 1'b0;
            hold_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            if (we_q) count_q <= count_q + 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        state_q <= ST_LOAD;
                        busy_q  <= 1'b1;
                        err_q   <= 1'b0;
                        count_q <= '0;
                        addr_q  <= BASE;
                        hold_q  <= 1'b0;
                        wlast_q <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (hold_q) begin
                        // The held write lands this cycle; a non-LAST one means the address space ran out.
                        hold_q <= 1'b0;
                        busy_q <= 1'b0;
                        if (wlast_q) begin
                            state_q <= ST_FIN;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            err_q   <= 1'b1;
                        end
                    end else if (hs) begin
                        if (enc_illegal) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end else begin
                            we_q    <= 1'b1;
                            wdata_q <= enc_word;
                            waddr_q <= addr_q;
                            addr_q  <= addr_d;
                            wlast_q <= REQ_LAST;
                            hold_q  <= REQ_LAST || (addr_q == ADDR_MAX);
                        end
                    end
                end
                ST_FIN:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign MEM_WE    = we_q;
    assign MEM_ADDR  = waddr_q;
    assign MEM_WDATA = wdata_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ERR       = err_q;
    assign COUNT     = count_q;

endmodule

// File: tb/tb_rv_program_loader.sv
// Directed bench for rv_program_loader: encodings, handshake timing, range errors,
// address-space exhaustion (second instance with ADDR_W=2) and asynchronous reset.
module tb_rv_program_loader;
    import rv_enc_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        START = 1'b0;
    logic        REQ_VALID = 1'b0;
    logic [3:0]  REQ_KIND = '0;
    logic [2:0]  REQ_FUNCT3 = '0;
    logic        REQ_F7B5 = 1'b0;
    logic [4:0]  REQ_RD = '0, REQ_RS1 = '0, REQ_RS2 = '0;
    logic [31:0] REQ_IMM = '0;
    logic        REQ_LAST = 1'b0;

    logic        REQ_READY, MEM_WE, BUSY, DONE, ERR;
    logic [7:0]  MEM_ADDR, COUNT;
    logic [31:0] MEM_WDATA;

    logic        d2_ready, d2_we, d2_busy, d2_done, d2_err;
    logic [1:0]  d2_addr, d2_count;
    logic [31:0] d2_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    rv_program_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_KIND(REQ_KIND), .REQ_FUNCT3(REQ_FUNCT3), .REQ_F7B5(REQ_F7B5), .REQ_RD(REQ_RD),
        .REQ_RS1(REQ_RS1), .REQ_RS2(REQ_RS2), .REQ_IMM(REQ_IMM), .REQ_LAST(REQ_LAST),
        .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .BUSY(BUSY),
        .DONE(DONE), .ERR(ERR), .COUNT(COUNT)
    );

    rv_program_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
        .CLK(CLK), .RST_N(RST_N), .START(START), .REQ_VALID(REQ_VALID), .REQ_READY(d2_ready),
        .REQ_KIND(REQ_KIND), .REQ_FUNCT3(REQ_FUNCT3), .REQ_F7B5(REQ_F7B5), .REQ_RD(REQ_RD),
        .REQ_RS1(REQ_RS1), .REQ_RS2(REQ_RS2), .REQ_IMM(REQ_IMM), .REQ_LAST(REQ_LAST),
        .MEM_WE(d2_we), .MEM_ADDR(d2_addr), .MEM_WDATA(d2_wdata), .BUSY(d2_busy),
        .DONE(d2_done), .ERR(d2_err), .COUNT(d2_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_load();
        START = 1'b1;
        step();
        START = 1'b0;
    endtask

    // Present one request for one edge; valid stays high so consecutive calls are back-to-back.
    task automatic send(input instr_kind_t k, input logic [2:0] f3, input logic f7,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic last);
        REQ_VALID  = 1'b1;
        REQ_KIND   = k;
        REQ_FUNCT3 = f3;
        REQ_F7B5   = f7;
        REQ_RD     = rd;
        REQ_RS1    = rs1;
        REQ_RS2    = rs2;
        REQ_IMM    = imm;
        REQ_LAST   = last;
        step();
    endtask

    task automatic drop_valid();
        REQ_VALID = 1'b0;
        REQ_LAST  = 1'b0;
    endtask

    initial begin
        int d2_writes, d2_zero_writes;
        logic [1:0] d2_exp_addr;

        // Reset state
        #12;
        chk("rst_we",    32'(MEM_WE), 32'd0);
        chk("rst_addr",  32'(MEM_ADDR), 32'd0);
        chk("rst_busy",  32'(BUSY), 32'd0);
        chk("rst_done",  32'(DONE), 32'd0);
        chk("rst_err",   32'(ERR), 32'd0);
        chk("rst_count", 32'(COUNT), 32'd0);
        chk("rst_ready", 32'(REQ_READY), 32'd0);
        RST_N = 1'b1;
        step();

        // ADDI x1,x0,5 then LAST ADD x3,x1,x2
        start_load();
        chk("ld_busy",  32'(BUSY), 32'd1);
        chk("ld_ready", 32'(REQ_READY), 32'd1);
        send(KIND_I_ALU, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        chk("addi_we",   32'(MEM_WE), 32'd1);
        chk("addi_word", MEM_WDATA, 32'h00500093);
        chk("addi_addr", 32'(MEM_ADDR), 32'd0);
        send(KIND_R, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
        drop_valid();
        chk("add_we",    32'(MEM_WE), 32'd1);
        chk("add_word",  MEM_WDATA, 32'h002081B3);
        chk("add_addr",  32'(MEM_ADDR), 32'd1);
        chk("hold_ready", 32'(REQ_READY), 32'd0);
        chk("done_early", 32'(DONE), 32'd0);
        step();
        chk("fin_done",  32'(DONE), 32'd1);
        chk("fin_busy",  32'(BUSY), 32'd0);
        chk("fin_we",    32'(MEM_WE), 32'd0);
        chk("fin_count", 32'(COUNT), 32'd2);
        step();
        chk("done_pulse", 32'(DONE), 32'd0);

        // Encodings of the other formats
        start_load();
        send(KIND_STORE, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
        chk("sw_word", MEM_WDATA, 32'h0020A423);
        send(KIND_BRANCH, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
        chk("beq_word", MEM_WDATA, 32'h00208463);
        send(KIND_JAL, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd16, 1'b0);
        chk("jal_word", MEM_WDATA, 32'h010000EF);
        send(KIND_LUI, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1);
        drop_valid();
        chk("lui_word", MEM_WDATA, 32'h123452B7);
        chk("lui_addr", 32'(MEM_ADDR), 32'd3);
        step();
        chk("enc_done",  32'(DONE), 32'd1);
        chk("enc_count", 32'(COUNT), 32'd4);
        step();

        // Back-to-back: one write per cycle at consecutive addresses
        start_load();
        for (int i = 0; i < 4; i++) begin
            send(KIND_I_ALU, 3'b000, 1'b0, 5'd1, 5'd1, 5'd0, 32'(i), i == 3);
            chk($sformatf("b2b_we%0d", i),   32'(MEM_WE), 32'd1);
            chk($sformatf("b2b_addr%0d", i), 32'(MEM_ADDR), 32'(i));
        end
        drop_valid();
        step();
        chk("b2b_done", 32'(DONE), 32'd1);
        step();

        // A valid gap produces a write bubble
        start_load();
        send(KIND_I_ALU, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0);
        drop_valid();
        step();
        chk("gap_bubble", 32'(MEM_WE), 32'd0);
        send(KIND_I_ALU, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 32'd2, 1'b1);
        drop_valid();
        chk("gap_we",   32'(MEM_WE), 32'd1);
        chk("gap_addr", 32'(MEM_ADDR), 32'd1);
        step();
        step();

        // Range errors: ADDI 2048, BRANCH odd, LUI with low bits set
        start_load();
        send(KIND_I_ALU, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);
        drop_valid();
        chk("addi_rng_we",   32'(MEM_WE), 32'd0);
        chk("addi_rng_err",  32'(ERR), 32'd1);
        chk("addi_rng_busy", 32'(BUSY), 32'd0);
        start_load();
        chk("start_clr_err", 32'(ERR), 32'd0);
        send(KIND_BRANCH, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0);
        drop_valid();
        chk("br_rng_we",   32'(MEM_WE), 32'd0);
        chk("br_rng_err",  32'(ERR), 32'd1);
        chk("br_rng_busy", 32'(BUSY), 32'd0);
        start_load();
        send(KIND_LUI, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h00000001, 1'b1);
        drop_valid();
        chk("lui_rng_we",   32'(MEM_WE), 32'd0);
        chk("lui_rng_err",  32'(ERR), 32'd1);
        chk("lui_rng_done", 32'(DONE), 32'd0);
        step();
        chk("lui_rng_no_done", 32'(DONE), 32'd0);
        start_load();
        chk("start_clr_err2", 32'(ERR), 32'd0);
        send(KIND_I_ALU, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFFF800, 1'b1);
        drop_valid();
        chk("addi_min_word", MEM_WDATA, 32'h80000093);
        step();
        step();

        // Address exhaustion on the 2-bit instance: writes 0..3 then ERR, no wrap to 0
        start_load();
        d2_writes = 0;
        d2_zero_writes = 0;
        d2_exp_addr = 2'd0;
        for (int i = 0; i < 5; i++) begin
            send(KIND_I_ALU, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'(i), i == 4);
            if (d2_we) begin
                chk($sformatf("wrap_addr%0d", d2_writes), 32'(d2_addr), 32'(d2_exp_addr));
                d2_exp_addr = d2_exp_addr + 2'd1;
                d2_writes++;
                if (d2_addr == 2'd0) d2_zero_writes++;
            end
        end
        drop_valid();
        chk("wrap_err",  32'(d2_err), 32'd1);
        chk("wrap_busy", 32'(d2_busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            if (d2_we) begin
                d2_writes++;
                if (d2_addr == 2'd0) d2_zero_writes++;
            end
            step();
        end
        chk("wrap_writes", 32'(d2_writes), 32'd4);
        chk("wrap_zero",   32'(d2_zero_writes), 32'd1);
        chk("wrap_done",   32'(d2_done), 32'd0);

        // Asynchronous reset in the middle of a burst
        start_load();
        send(KIND_I_ALU, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd7, 1'b0);
        send(KIND_I_ALU, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 32'd8, 1'b0);
        chk("pre_rst_we", 32'(MEM_WE), 32'd1);
        #2 RST_N = 1'b0;
        #1;
        chk("arst_we",    32'(MEM_WE), 32'd0);
        chk("arst_busy",  32'(BUSY), 32'd0);
        chk("arst_ready", 32'(REQ_READY), 32'd0);
        chk("arst_count", 32'(COUNT), 32'd0);
        chk("arst_addr",  32'(MEM_ADDR), 32'd0);
        drop_valid();
        step();
        chk("rst_no_we", 32'(MEM_WE), 32'd0);
        RST_N = 1'b1;
        step();
        start_load();
        send(KIND_I_ALU, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
        drop_valid();
        chk("post_rst_addr", 32'(MEM_ADDR), 32'd0);
        chk("post_rst_word", MEM_WDATA, 32'h00500093);
        step();
        chk("post_rst_done",  32'(DONE), 32'd1);
        chk("post_rst_count", 32'(COUNT), 32'd1);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
